// File: rtl/ensemble_pkg.sv
// Shared types and constants for the ensemble majority-vote combiner.
// Holds the FSM state encoding, the result field offsets and the match-counter width helper.
package ensemble_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VOTE    = 2'd1,
        OUT     = 2'd2
    } state_t;

    localparam int LABEL_LSB     = 0;
    localparam int COUNT_LSB     = 8;
    localparam int UNANIMOUS_BIT = 16;

    // Bits needed to hold a match count of 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ensemble_match_counter.sv
// Combinational match counter: counts how many stored labels equal the candidate label.
// Uses one equality comparator per channel, followed by a popcount of the match bits.
module ensemble_match_counter #(
    parameter int NUM_CLASSIFIERS = 3,
    parameter int CLASS_WIDTH     = 8,
    parameter int CNT_W           = 2
) (
    input  logic [NUM_CLASSIFIERS*CLASS_WIDTH-1:0] i_labels,
    input  logic [CLASS_WIDTH-1:0]                 i_cand,
    output logic [CNT_W-1:0]                       o_count
);

    logic [NUM_CLASSIFIERS-1:0] w_match;

    generate
        for (genvar gi = 0; gi < NUM_CLASSIFIERS; gi++) begin : g_cmp
            assign w_match[gi] = (i_labels[gi*CLASS_WIDTH +: CLASS_WIDTH] == i_cand);
        end
    endgenerate

    always_comb begin
        o_count = '0;
        for (int j = 0; j < NUM_CLASSIFIERS; j++) begin
            o_count = o_count + CNT_W'(w_match[j]);
        end
    end

endmodule

// File: rtl/ensemble_vote_combiner.sv
// Collects one label beat per classifier stream, then evaluates the candidates one per cycle
// to form a majority vote, and emits a single AXI-Stream result beat per sample.
module ensemble_vote_combiner
    import ensemble_pkg::*;
#(
    parameter int NUM_CLASSIFIERS = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int KEEP_WIDTH      = 4,
    parameter int CLASS_WIDTH     = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CLASSIFIERS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CLASSIFIERS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_CLASSIFIERS-1:0]            s_axis_tvalid,
    output logic [NUM_CLASSIFIERS-1:0]            s_axis_tready,
    input  logic [NUM_CLASSIFIERS-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]                 m_axis_tkeep,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic [31:0]                           sample_count,
    output logic                                  err_last_mismatch
);

    localparam int CNT_W  = cnt_width(NUM_CLASSIFIERS);
    localparam int CAND_W = (NUM_CLASSIFIERS > 1) ? $clog2(NUM_CLASSIFIERS) : 1;

    state_t                                r_state;
    logic [NUM_CLASSIFIERS-1:0]            r_captured;
    logic [NUM_CLASSIFIERS*CLASS_WIDTH-1:0] r_labels;
    logic [NUM_CLASSIFIERS-1:0]            r_lasts;
    logic [CAND_W-1:0]                     r_cand;
    logic [CNT_W-1:0]                      r_best_cnt;
    logic [CLASS_WIDTH-1:0]                r_best_label;
    logic [DATA_WIDTH-1:0]                 r_m_tdata;
    logic                                  r_m_tvalid;
    logic                                  r_m_tlast;
    logic [31:0]                           r_sample_count;
    logic                                  r_err;

    logic [NUM_CLASSIFIERS-1:0]            w_fire;
    logic [NUM_CLASSIFIERS-1:0]            w_captured_next;
    logic [CLASS_WIDTH-1:0]                w_cand_label;
    logic [CNT_W-1:0]                      w_match_cnt;
    logic                                  w_better;
    logic [CNT_W-1:0]                      w_best_cnt_next;
    logic [CLASS_WIDTH-1:0]                w_best_label_next;
    logic [DATA_WIDTH-1:0]                 w_result;
    logic                                  w_last_mismatch;
    logic                                  w_unused;

    assign w_fire          = (r_state == COLLECT) ? (s_axis_tvalid & ~r_captured) : '0;
    assign w_captured_next = r_captured | w_fire;
    assign s_axis_tready   = (r_state == COLLECT) ? ~r_captured : '0;

    assign w_cand_label = r_labels[int'(r_cand)*CLASS_WIDTH +: CLASS_WIDTH];

    ensemble_match_counter #(
        .NUM_CLASSIFIERS (NUM_CLASSIFIERS),
        .CLASS_WIDTH     (CLASS_WIDTH),
        .CNT_W           (CNT_W)
    ) u_match_counter (
        .i_labels (r_labels),
        .i_cand   (w_cand_label),
        .o_count  (w_match_cnt)
    );

    // Strict greater-than keeps the earliest candidate on ties.
    assign w_better          = (w_match_cnt > r_best_cnt);
    assign w_best_cnt_next   = w_better ? w_match_cnt  : r_best_cnt;
    assign w_best_label_next = w_better ? w_cand_label : r_best_label;
    assign w_last_mismatch   = (r_lasts != '0) && (r_lasts != '1);

    always_comb begin
        w_result = '0;
        w_result[LABEL_LSB +: 8] = 8'(w_best_label_next);
        w_result[COUNT_LSB +: 8] = 8'(w_best_cnt_next);
        w_result[UNANIMOUS_BIT]  = (w_best_cnt_next == CNT_W'(NUM_CLASSIFIERS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_labels <= '0;
            r_lasts  <= '0;
        end else begin
            for (int i = 0; i < NUM_CLASSIFIERS; i++) begin
                if (w_fire[i]) begin
                    r_labels[i*CLASS_WIDTH +: CLASS_WIDTH] <= s_axis_tdata[i*DATA_WIDTH +: CLASS_WIDTH];
                    r_lasts[i] <= s_axis_tlast[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= COLLECT;
            r_captured     <= '0;
            r_cand         <= '0;
            r_best_cnt     <= '0;
            r_best_label   <= '0;
            r_m_tdata      <= '0;
            r_m_tvalid     <= 1'b0;
            r_m_tlast      <= 1'b0;
            r_sample_count <= '0;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    r_captured <= w_captured_next;
                    if (&w_captured_next) begin
                        r_state      <= VOTE;
                        r_cand       <= '0;
                        r_best_cnt   <= '0;
                        r_best_label <= '0;
                    end
                end
                VOTE: begin
                    r_best_cnt   <= w_best_cnt_next;
                    r_best_label <= w_best_label_next;
                    if (r_cand == CAND_W'(NUM_CLASSIFIERS - 1)) begin
                        r_m_tdata  <= w_result;
                        r_m_tlast  <= r_lasts[0];
                        r_m_tvalid <= 1'b1;
                        r_state    <= OUT;
                        if (w_last_mismatch) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cand <= r_cand + 1'b1;
                    end
                end
                OUT: begin
                    if (m_axis_tready) begin
                        r_m_tvalid     <= 1'b0;
                        r_sample_count <= r_sample_count + 32'd1;
                        r_captured     <= '0;
                        r_state        <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign m_axis_tdata      = r_m_tdata;
    assign m_axis_tkeep      = '1;
    assign m_axis_tvalid     = r_m_tvalid;
    assign m_axis_tlast      = r_m_tlast;
    assign sample_count      = r_sample_count;
    assign err_last_mismatch = r_err;

    // Label bits above CLASS_WIDTH and the keep strobes carry no vote information.
    assign w_unused = ^{s_axis_tkeep, s_axis_tdata};

endmodule
